// File: rtl/rate_div_pkg.sv
// rate_div_pkg: shared constants for the rate divider / tick counter.
// Default divisor table contents, speed-select width and speed-code names.
package rate_div_pkg;

    localparam int SPEED_W    = 2;
    localparam int NUM_SPEEDS = 1 << SPEED_W;

    localparam int DIV0_DEF = 0;
    localparam int DIV1_DEF = 499;
    localparam int DIV2_DEF = 999;
    localparam int DIV3_DEF = 1999;

    typedef enum logic [SPEED_W-1:0] {
        SPD_STOP = 2'd0,
        SPD_FAST = 2'd1,
        SPD_MED  = 2'd2,
        SPD_SLOW = 2'd3
    } speed_e;

endpackage

// File: rtl/mod_counter.sv
// mod_counter: up/down counter modulo CNT_MOD, advanced by i_tick.
// Ports: i_clk, i_rst (sync, active-high), i_tick, i_up -> o_value, o_wrap.
module mod_counter
    import rate_div_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int CNT_MOD = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_up,
    output logic [CNT_W-1:0] o_value,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MOD - 1);

    logic [CNT_W-1:0] r_value;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_value == LP_MAX);
    assign w_at_min = (r_value == '0);

    // Terminal count depends on direction sampled in the tick cycle.
    assign o_wrap  = i_tick & (i_up ? w_at_max : w_at_min);
    assign o_value = r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_tick) begin
            if (i_up) begin
                r_value <= w_at_max ? '0 : r_value + CNT_W'(1);
            end else begin
                r_value <= w_at_min ? LP_MAX : r_value - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rate_tick_counter.sv
// rate_tick_counter: table-driven rate divider feeding a modulo up/down counter.
// Ports: ClockIn, Reset, Enable, Speed, Restart, Up -> DivCount, Tick,
//   CounterValue, Wrap. With RATE_DIV_LOAD_EN defined the divisor table is
//   writable via LoadValid/LoadSel/LoadDivisor with LoadReady.
module rate_tick_counter
    import rate_div_pkg::*;
#(
    parameter int DIV_W   = 11,
    parameter int CNT_W   = 4,
    parameter int CNT_MOD = 16,
    parameter int DIV0    = DIV0_DEF,
    parameter int DIV1    = DIV1_DEF,
    parameter int DIV2    = DIV2_DEF,
    parameter int DIV3    = DIV3_DEF
) (
    input  logic               ClockIn,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [SPEED_W-1:0] Speed,
    input  logic               Restart,
    input  logic               Up,
`ifdef RATE_DIV_LOAD_EN
    input  logic               LoadValid,
    input  logic [SPEED_W-1:0] LoadSel,
    input  logic [DIV_W-1:0]   LoadDivisor,
    output logic               LoadReady,
`endif
    output logic [DIV_W-1:0]   DivCount,
    output logic               Tick,
    output logic [CNT_W-1:0]   CounterValue,
    output logic               Wrap
);

    logic [DIV_W-1:0] w_table [NUM_SPEEDS];
    logic [DIV_W-1:0] w_div_sel;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

`ifdef RATE_DIV_LOAD_EN
    logic [DIV_W-1:0] r_table [NUM_SPEEDS];

    assign LoadReady = ~Reset;

    // Reload reads r_table before this edge, so a colliding write
    // only affects later reloads.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_table[0] <= DIV_W'(DIV0);
            r_table[1] <= DIV_W'(DIV1);
            r_table[2] <= DIV_W'(DIV2);
            r_table[3] <= DIV_W'(DIV3);
        end else if (LoadValid && LoadReady) begin
            r_table[LoadSel] <= LoadDivisor;
        end
    end

    assign w_table = r_table;
`else
    assign w_table[0] = DIV_W'(DIV0);
    assign w_table[1] = DIV_W'(DIV1);
    assign w_table[2] = DIV_W'(DIV2);
    assign w_table[3] = DIV_W'(DIV3);
`endif

    always_comb begin
        w_div_sel = w_table[0];
        unique case (speed_e'(Speed))
            SPD_STOP: w_div_sel = w_table[0];
            SPD_FAST: w_div_sel = w_table[1];
            SPD_MED:  w_div_sel = w_table[2];
            SPD_SLOW: w_div_sel = w_table[3];
        endcase
    end

    // Restart suppresses the tick so it can never advance the counter.
    assign w_tick = ~Reset & Enable & ~Restart & (r_div == '0);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_div <= '0;
        end else if (Restart) begin
            r_div <= w_div_sel;
        end else if (!Enable) begin
            r_div <= r_div;
        end else if (r_div == '0) begin
            r_div <= w_div_sel;
        end else begin
            r_div <= r_div - DIV_W'(1);
        end
    end

    assign DivCount = r_div;
    assign Tick     = w_tick;

    mod_counter #(
        .CNT_W   (CNT_W),
        .CNT_MOD (CNT_MOD)
    ) u_cnt (
        .i_clk   (ClockIn),
        .i_rst   (Reset),
        .i_tick  (w_tick),
        .i_up    (Up),
        .o_value (CounterValue),
        .o_wrap  (Wrap)
    );

endmodule
